// File: rtl/hilotof_result_arbiter.sv
// hilotof_result_arbiter
//   Shares the single 32-bit result channel of hilotof_io between NUM_SRC
//   producers. Round-robin arbitration feeds a registered holding stage; each
//   word can be tagged with its source index in bits [31:28]. A flush (DUT
//   reset) discards any held word, and a sticky flag reports a downstream that
//   has not accepted a held word for STALL_CYCLES consecutive cycles.
//
// Ports
//   clock        system clock
//   sys_reset_n  asynchronous active-low reset
//   flush        synchronous active-high flush
//   src_dout     source i data at [32*i+31:32*i]
//   src_valid    source i has a word
//   src_ready    accept strobe per source (one-hot or zero)
//   out_dout     registered result word
//   out_valid    out_dout holds an untransferred word
//   out_ready    downstream accept
//   grant_idx    source index of the word in out_dout
//   out_stall    sticky downstream-stall flag
module hilotof_result_arbiter #(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned TAG_EN       = 1,
    parameter int unsigned STALL_CYCLES = 65535,
    localparam int unsigned IW          = $clog2(NUM_SRC),
    localparam int unsigned CW          = $clog2(STALL_CYCLES + 1)
) (
    input  logic                   clock,
    input  logic                   sys_reset_n,
    input  logic                   flush,
    input  logic [32*NUM_SRC-1:0]  src_dout,
    input  logic [NUM_SRC-1:0]     src_valid,
    output logic [NUM_SRC-1:0]     src_ready,
    output logic [31:0]            out_dout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IW-1:0]          grant_idx,
    output logic                   out_stall
);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_rr_ptr;
    logic [31:0]     r_out_dout;
    logic            r_out_valid;
    logic [IW-1:0]   r_grant_idx;
    logic            r_out_stall;
    logic [CW-1:0]   r_stall_cnt;

    logic [31:0]     w_src [NUM_SRC];
    logic            w_found;
    logic [IW-1:0]   w_g;
    logic [IW:0]     w_sum;
    logic [3:0]      w_tag;
    logic [31:0]     w_word;
    logic            w_grant;
    logic [IW-1:0]   w_next_ptr;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign w_src[gi] = src_dout[32*gi +: 32];
    end

    // Round-robin search starting at r_rr_ptr; the sum is kept one bit wider
    // so the modulo wrap also works when NUM_SRC is not a power of two.
    always_comb begin
        w_found = 1'b0;
        w_g     = '0;
        w_sum   = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NUM_SRC)) begin
                w_sum = w_sum - (IW+1)'(NUM_SRC);
            end
            if (!w_found && src_valid[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_g     = w_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        w_tag         = '0;
        w_tag[IW-1:0] = w_g;
        if (TAG_EN != 0) begin
            w_word = {w_tag, w_src[w_g][27:0]};
        end else begin
            w_word = w_src[w_g];
        end
    end

    // Reset is folded in so no source sees an accept while reset is asserted.
    assign w_grant   = sys_reset_n && (r_state == ST_IDLE) && w_found && !flush;
    assign src_ready = w_grant ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << w_g) : '0;

    assign w_next_ptr = (r_grant_idx == IW'(NUM_SRC - 1)) ? '0 : r_grant_idx + IW'(1);

    always_ff @(posedge clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_out_dout  <= '0;
            r_out_valid <= 1'b0;
            r_grant_idx <= '0;
            r_out_stall <= 1'b0;
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
            r_stall_cnt <= '0;
            r_out_stall <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_out_dout  <= w_word;
                        r_grant_idx <= w_g;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_rr_ptr    <= w_next_ptr;
                        r_stall_cnt <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        if (r_stall_cnt != CW'(STALL_CYCLES)) begin
                            r_stall_cnt <= r_stall_cnt + CW'(1);
                        end
                        // Compare against the pre-increment value so the flag
                        // rises on the edge where the count reaches the limit.
                        if (r_stall_cnt >= CW'(STALL_CYCLES - 1)) begin
                            r_out_stall <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_dout  = r_out_dout;
    assign out_valid = r_out_valid;
    assign grant_idx = r_grant_idx;
    assign out_stall = r_out_stall;

endmodule

// File: tb/tb_hilotof_result_arbiter.sv
// tb_hilotof_result_arbiter
//   Scoreboard bench for hilotof_result_arbiter: a 4-source tagged instance
//   driven by directed and random traffic against a transaction-level model,
//   and a 3-source untagged instance for the raw-word / wrap case.
module tb_hilotof_result_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         fl;
    logic [127:0] sdout;
    logic [3:0]   sval;
    logic [3:0]   srdy;
    logic [31:0]  odout;
    logic         oval;
    logic         ordy;
    logic [1:0]   gidx;
    logic         ostall;

    logic [95:0]  sdout3;
    logic [2:0]   sval3;
    logic [2:0]   srdy3;
    logic [31:0]  odout3;
    logic         oval3;
    logic         ordy3;
    logic [1:0]   gidx3;
    logic         ostall3;

    hilotof_result_arbiter #(.NUM_SRC(4), .TAG_EN(1), .STALL_CYCLES(8)) dut (
        .clock(clk), .sys_reset_n(rst_n), .flush(fl),
        .src_dout(sdout), .src_valid(sval), .src_ready(srdy),
        .out_dout(odout), .out_valid(oval), .out_ready(ordy),
        .grant_idx(gidx), .out_stall(ostall)
    );

    hilotof_result_arbiter #(.NUM_SRC(3), .TAG_EN(0), .STALL_CYCLES(8)) dut3 (
        .clock(clk), .sys_reset_n(rst_n), .flush(fl),
        .src_dout(sdout3), .src_valid(sval3), .src_ready(srdy3),
        .out_dout(odout3), .out_valid(oval3), .out_ready(ordy3),
        .grant_idx(gidx3), .out_stall(ostall3)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] w;
        logic [1:0]  g;
    } exp_t;

    exp_t q[$];
    exp_t q3[$];

    // Transaction-level model of the 4-source instance
    bit          m_busy;
    int          m_ptr;
    int          m_gidx;
    int          m_cnt;
    bit          m_stall;
    logic [31:0] d [4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && oval && ordy) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h expected none", odout);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_dout", odout, e.w);
                check("grant_idx", {30'd0, gidx}, {30'd0, e.g});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && oval3 && ordy3) begin
            if (q3.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word3: got %h expected none", odout3);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("out_dout3", odout3, e.w);
                check("grant_idx3", {30'd0, gidx3}, {30'd0, e.g});
            end
        end
    end

    // One cycle: new requests, model prediction, mid-cycle checks, model update.
    task automatic step(input logic [3:0] allow, input int pct, input logic rdy, input logic f);
        logic [3:0] expr;
        logic [3:0] acc;
        int         g;
        bit         any;
        for (int i = 0; i < 4; i++) begin
            if (!sval[i] && allow[i] && ($urandom_range(99) < pct)) begin
                sval[i] = 1'b1;
                d[i]    = $urandom;
            end
        end
        sdout = {d[3], d[2], d[1], d[0]};
        ordy  = f ? 1'b0 : rdy;
        fl    = f;
        any = 0;
        g   = 0;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (!any && sval[idx]) begin
                any = 1;
                g   = idx;
            end
        end
        expr = (!m_busy && any && !f) ? 4'(1 << g) : 4'b0;
        @(negedge clk);
        check("src_ready", {28'd0, srdy}, {28'd0, expr});
        check("out_valid", {31'd0, oval}, {31'd0, m_busy});
        check("out_stall", {31'd0, ostall}, {31'd0, m_stall});
        if (expr != 4'b0) begin
            q.push_back('{{4'(g), d[g][27:0]}, 2'(g)});
        end
        acc = sval & srdy;
        @(posedge clk);
        #2;
        sval = sval & ~acc;
        if (f) begin
            m_busy  = 0;
            m_ptr   = 0;
            m_cnt   = 0;
            m_stall = 0;
            q.delete();
        end else if (m_busy) begin
            if (ordy) begin
                m_busy = 0;
                m_ptr  = (m_gidx + 1) % 4;
                m_cnt  = 0;
            end else begin
                if (m_cnt < 8) m_cnt++;
                if (m_cnt >= 8) m_stall = 1;
            end
        end else if (expr != 4'b0) begin
            m_busy = 1;
            m_gidx = g;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, oval}, 32'd0);
        check("arst_out_dout", odout, 32'd0);
        check("arst_src_ready", {28'd0, srdy}, 32'd0);
        m_busy  = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_stall = 0;
        q.delete();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; fl = 1'b0; ordy = 1'b0;
        sval = '0; sdout = '0;
        sval3 = '0; sdout3 = '0; ordy3 = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = '0;
        m_busy = 0; m_ptr = 0; m_gidx = 0; m_cnt = 0; m_stall = 0;

        // Reset values, with requests present to show src_ready stays low
        repeat (2) @(negedge clk);
        sval  = 4'hF;
        sval3 = 3'b111;
        #1;
        check("rst_out_valid", {31'd0, oval}, 32'd0);
        check("rst_out_dout", odout, 32'd0);
        check("rst_grant_idx", {30'd0, gidx}, 32'd0);
        check("rst_out_stall", {31'd0, ostall}, 32'd0);
        check("rst_src_ready", {28'd0, srdy}, 32'd0);
        check("rst_src_ready3", {29'd0, srdy3}, 32'd0);
        check("rst_out_valid3", {31'd0, oval3}, 32'd0);
        sval  = '0;
        sval3 = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single request from source 2 with a known word
        d[2] = 32'h0ABCDEF1;
        sval = 4'b0100;
        step(4'b0000, 0, 1'b1, 1'b0);
        #1;
        check("t1_out_dout", odout, 32'h2ABCDEF1);
        check("t1_grant_idx", {30'd0, gidx}, 32'd2);
        repeat (3) step(4'b0000, 0, 1'b1, 1'b0);

        // All sources requesting continuously
        repeat (16) step(4'hF, 100, 1'b1, 1'b0);
        repeat (10) step(4'b0000, 0, 1'b1, 1'b0);

        // Downstream blocked while sources 1 and 3 request
        repeat (10) step(4'b1010, 100, 1'b0, 1'b0);
        repeat (8) step(4'b0000, 0, 1'b1, 1'b0);

        // Stall flag, then flush
        repeat (12) step(4'hF, 100, 1'b0, 1'b0);
        step(4'b0000, 0, 1'b0, 1'b1);
        repeat (10) step(4'hF, 0, 1'b1, 1'b0);

        // Asynchronous reset while a word is held
        repeat (3) step(4'b0110, 100, 1'b0, 1'b0);
        pulse_reset();
        repeat (8) step(4'b0000, 0, 1'b1, 1'b0);

        // Random traffic, back-pressure and occasional flushes
        repeat (600) step(4'($urandom), int'($urandom_range(100)),
                          ($urandom_range(3) != 0), ($urandom_range(40) == 0));
        repeat (20) step(4'b0000, 0, 1'b1, 1'b0);
        check("scoreboard_empty", q.size(), 32'd0);

        // Three untagged sources, all requesting: raw words in order 0,1,2,0,1,2
        for (int i = 0; i < 6; i++) begin
            q3.push_back('{32'hFFFF0000 + 32'(i % 3), 2'(i % 3)});
        end
        sdout3 = {32'hFFFF0002, 32'hFFFF0001, 32'hFFFF0000};
        ordy3  = 1'b1;
        sval3  = 3'b111;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #2;
            if (q3.size() == 0) break;
        end
        sval3 = '0;
        repeat (3) @(negedge clk);
        check("scoreboard3_empty", q3.size(), 32'd0);
        check("t6_out_valid3_idle", {31'd0, oval3}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
